// File: rtl/fadd_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fadd_seq_ctrl
//
// Sequencing FSM for the single-precision float adder datapath. It walks an
// accepted operation through exponent alignment, mantissa add and
// post-add normalisation. It steers the 28-bit mantissa shifter and the
// mantissa adder, and it produces the result exponent together with the
// overflow/underflow flags.
//
// Mantissa layout (MANT_W = 28):
//    [27] carry, [26] hidden bit, [25:3] fraction, [2:0] guard/round/sticky
//
// Optional feature macro: FADD_ROUND_EN
//    When it is defined, ROUND and RENORM states follow NORM and perform
//    round-to-nearest-even. The latency is then 5 cycles, or 6 when rounding
//    carries out of the mantissa.
//    When it is undefined, the result is truncated, round_inc_o is tied to 0
//    and the latency is 4 cycles.
//
// Ports:
//    clk_i               clock, rising edge
//    res_i               synchronous active-low reset
//    start_i             operation request, sampled only in IDLE
//    exp_a_i, exp_b_i    operand exponents
//    sum_mant_i          current datapath mantissa register
//    sel_swap_o          1 = operand A is routed to the shifter
//    shift_right_en_o    shifter right-shift enable (1-cycle pulse)
//    shift_right_bits_o  right-shift amount
//    shift_left_en_o     shifter left-shift enable (1-cycle pulse)
//    shift_left_bits_o   left-shift amount
//    add_en_o            mantissa adder enable (1-cycle pulse)
//    round_inc_o         rounding increment request
//    exp_out_o           result exponent, held until the next accepted start
//    busy_o              operation in flight (low in IDLE and DONE)
//    done_o              one-cycle completion pulse
//    overflow_o          result exponent saturated to all ones
//    underflow_o         result flushed to exponent 0
// ---------------------------------------------------------------------------
module fadd_seq_ctrl #(
   parameter int EXP_W     = 8,
   parameter int MANT_W    = 28,
   parameter int MAX_SHIFT = 27
) (
   input  logic              clk_i,
   input  logic              res_i,
   input  logic              start_i,
   input  logic [EXP_W-1:0]  exp_a_i,
   input  logic [EXP_W-1:0]  exp_b_i,
   input  logic [MANT_W-1:0] sum_mant_i,
   output logic              sel_swap_o,
   output logic              shift_right_en_o,
   output logic [7:0]        shift_right_bits_o,
   output logic              shift_left_en_o,
   output logic [7:0]        shift_left_bits_o,
   output logic              add_en_o,
   output logic              round_inc_o,
   output logic [EXP_W-1:0]  exp_out_o,
   output logic              busy_o,
   output logic              done_o,
   output logic              overflow_o,
   output logic              underflow_o
);

`ifdef FADD_ROUND_EN
   typedef enum logic [2:0] {
      S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE, S_ROUND, S_RENORM
   } state_t;
`else
   typedef enum logic [2:0] {
      S_IDLE, S_ALIGN, S_ADD, S_NORM, S_DONE
   } state_t;
`endif

   state_t             state_q, state_d;
   logic               selSwap_q, selSwap_d;
   logic [EXP_W-1:0]   diff_q, diff_d;
   logic [EXP_W-1:0]   expR_q, expR_d;
   logic [EXP_W-1:0]   expOut_q, expOut_d;
   logic               overflow_q, overflow_d;
   logic               underflow_q, underflow_d;
   logic [7:0]         leadZeros;
   logic [EXP_W:0]     expInc;

`ifndef FADD_ROUND_EN
   logic               unusedRoundBits;
   assign unusedRoundBits = ^sum_mant_i[2:0];
`endif

   // Leading-zero count of the mantissa below the carry bit. The loop runs
   // from the LSB upwards, so the highest set bit writes last and wins. An
   // all-zero field yields MANT_W-1, but the NORM logic never uses that value
   // because it handles a zero mantissa separately.
   always_comb begin
      leadZeros = 8'(MANT_W - 1);
      for (int i = 0; i < MANT_W - 1; i++) begin
         if (sum_mant_i[i]) begin
            leadZeros = 8'(MANT_W - 2 - i);
         end
      end
   end

   // Exponent plus one, one bit wider, so that a saturating increment can
   // detect that it has reached the all-ones exponent.
   assign expInc = {1'b0, expR_q} + {{EXP_W{1'b0}}, 1'b1};

   // Next-state and output decode. Every datapath enable defaults to 0, so
   // each enable is a single-cycle pulse of the one state that raises it.
   always_comb begin
      state_d            = state_q;
      selSwap_d          = selSwap_q;
      diff_d             = diff_q;
      expR_d             = expR_q;
      expOut_d           = expOut_q;
      overflow_d         = overflow_q;
      underflow_d        = underflow_q;
      shift_right_en_o   = 1'b0;
      shift_right_bits_o = 8'd0;
      shift_left_en_o    = 1'b0;
      shift_left_bits_o  = 8'd0;
      add_en_o           = 1'b0;
      round_inc_o        = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               selSwap_d   = (exp_b_i > exp_a_i);
               diff_d      = (exp_b_i > exp_a_i) ? (exp_b_i - exp_a_i) : (exp_a_i - exp_b_i);
               expR_d      = (exp_b_i > exp_a_i) ? exp_b_i : exp_a_i;
               overflow_d  = 1'b0;
               underflow_d = 1'b0;
               state_d     = S_ALIGN;
            end
         end

         S_ALIGN: begin
            shift_right_en_o   = 1'b1;
            shift_right_bits_o = (diff_q > EXP_W'(MAX_SHIFT)) ? 8'(MAX_SHIFT) : 8'(diff_q);
            state_d            = S_ADD;
         end

         S_ADD: begin
            add_en_o = 1'b1;
            state_d  = S_NORM;
         end

         S_NORM: begin
            if (sum_mant_i[MANT_W-1]) begin
               shift_right_en_o   = 1'b1;
               shift_right_bits_o = 8'd1;
               if (expInc >= {1'b0, {EXP_W{1'b1}}}) begin
                  overflow_d = 1'b1;
                  expR_d     = {EXP_W{1'b1}};
               end else begin
                  expR_d = expInc[EXP_W-1:0];
               end
            end else if (sum_mant_i == '0) begin
               expR_d = '0;
            end else if ({{EXP_W{1'b0}}, leadZeros} < {8'd0, expR_q}) begin
               shift_left_en_o   = 1'b1;
               shift_left_bits_o = leadZeros;
               expR_d            = expR_q - EXP_W'(leadZeros);
            end else begin
               underflow_d = 1'b1;
               expR_d      = '0;
            end
`ifdef FADD_ROUND_EN
            state_d = S_ROUND;
`else
            state_d = S_DONE;
`endif
         end

`ifdef FADD_ROUND_EN
         S_ROUND: begin
            round_inc_o = sum_mant_i[2] & (sum_mant_i[1] | sum_mant_i[0] | sum_mant_i[3]);
            if (round_inc_o && (&sum_mant_i[MANT_W-2:3])) begin
               state_d = S_RENORM;
            end else begin
               state_d = S_DONE;
            end
         end

         S_RENORM: begin
            shift_right_en_o   = 1'b1;
            shift_right_bits_o = 8'd1;
            if (expInc >= {1'b0, {EXP_W{1'b1}}}) begin
               overflow_d = 1'b1;
               expR_d     = {EXP_W{1'b1}};
            end else begin
               expR_d = expInc[EXP_W-1:0];
            end
            state_d = S_DONE;
         end
`endif

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      // The result register is loaded on entry to DONE. It is therefore
      // already valid in the DONE cycle, and it keeps its value after that.
      if (state_d == S_DONE) begin
         expOut_d = expR_d;
      end
   end

   // State and datapath-control registers. A low reset at a clock edge puts
   // the FSM back in IDLE, so an operation in flight ends without a done
   // pulse.
   always_ff @(posedge clk_i) begin
      if (!res_i) begin
         state_q     <= S_IDLE;
         selSwap_q   <= 1'b0;
         diff_q      <= '0;
         expR_q      <= '0;
         expOut_q    <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         selSwap_q   <= selSwap_d;
         diff_q      <= diff_d;
         expR_q      <= expR_d;
         expOut_q    <= expOut_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   assign sel_swap_o  = selSwap_q;
   assign exp_out_o   = expOut_q;
   assign overflow_o  = overflow_q;
   assign underflow_o = underflow_q;
   assign done_o      = (state_q == S_DONE);
   assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule
